// File: rtl/conv_encoder_stream_pkg.sv
// Shared constants and the reference trellis step for the
// rate-1/2 convolutional encoder and its companion decoder.
package conv_encoder_stream_pkg;

  localparam int          K_DEF  = 3;
  localparam int          M_DEF  = K_DEF - 1;
  localparam logic [7:0]  G0_DEF = 8'o07;
  localparam logic [7:0]  G1_DEF = 8'o05;

  // One trellis step for constraint length k (3..7).
  // sr = {state, bit}; the newest bit sits in sr[0].
  // Returns {next_state[7:0], y0, y1}.
  function automatic logic [9:0] conv_step(
    input int         k,
    input logic [7:0] st,
    input logic       b,
    input logic [7:0] g0,
    input logic [7:0] g1
  );
    logic [8:0] msk;
    logic [8:0] sr;
    logic [7:0] nx;
    logic       y0;
    logic       y1;
    msk = (9'd1 << k) - 9'd1;
    sr  = {st, b} & msk;
    nx  = sr[7:0] & ((8'd1 << (k - 1)) - 8'd1);
    y0  = ^(sr & {1'b0, g0});
    y1  = ^(sr & {1'b0, g1});
    return {nx, y0, y1};
  endfunction

endpackage

// File: rtl/conv_encoder_stream.sv
// Streaming rate-1/2 convolutional encoder with a
// one-entry output slot and M zero tail bits per frame.
module conv_encoder_stream
  import conv_encoder_stream_pkg::*;
#(
  parameter int         K      = K_DEF,
  parameter logic [7:0] G0_OCT = G0_DEF,
  parameter logic [7:0] G1_OCT = G1_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic       i_in_bit,
  input  logic       i_in_last,
  output logic       o_sym_valid,
  input  logic       i_sym_ready,
  output logic [1:0] o_sym,
  output logic       o_sym_last,
  output logic       o_busy
);

  localparam int M  = K - 1;
  localparam int TW = $clog2(K);

  typedef enum logic {
    ST_RUN,
    ST_TAIL
  } fsm_t;

  fsm_t          r_fsm;
  logic [M-1:0]  r_enc;
  logic [TW-1:0] r_tail;
  logic [1:0]    r_sym;
  logic          r_sym_valid;
  logic          r_sym_last;

  logic          w_slot_free;
  logic          w_load_data;
  logic          w_load_tail;
  logic          w_bit;
  logic [9:0]    w_step;
  logic [7:0]    w_nx8;
  logic [M-1:0]  w_next;
  logic          w_tail_end;
  logic          w_unused;

  assign w_slot_free = !r_sym_valid || i_sym_ready;
  assign w_load_data = (r_fsm == ST_RUN) && i_in_valid && w_slot_free;
  assign w_load_tail = (r_fsm == ST_TAIL) && w_slot_free;
  assign w_bit       = (r_fsm == ST_TAIL) ? 1'b0 : i_in_bit;
  assign w_step      = conv_step(K, 8'(r_enc), w_bit, G0_OCT, G1_OCT);
  assign w_nx8       = w_step[9:2];
  assign w_next      = w_nx8[M-1:0];
  assign w_unused    = ^w_nx8;
  assign w_tail_end  = (r_tail == TW'(M - 1));

  assign o_in_ready  = (r_fsm == ST_RUN) && w_slot_free;
  assign o_busy      = (r_fsm == ST_TAIL) || r_sym_valid;
  assign o_sym       = r_sym;
  assign o_sym_valid = r_sym_valid;
  assign o_sym_last  = r_sym_last;

  // FSM, trellis state and output slot; slot refills in the
  // same cycle it drains so the stream never bubbles
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fsm       <= ST_RUN;
      r_enc       <= '0;
      r_tail      <= '0;
      r_sym       <= 2'b00;
      r_sym_valid <= 1'b0;
      r_sym_last  <= 1'b0;
    end else if (w_load_data) begin
      r_sym       <= w_step[1:0];
      r_sym_valid <= 1'b1;
      r_sym_last  <= 1'b0;
      r_enc       <= w_next;
      if (i_in_last) begin
        r_fsm  <= ST_TAIL;
        r_tail <= '0;
      end
    end else if (w_load_tail) begin
      r_sym       <= w_step[1:0];
      r_sym_valid <= 1'b1;
      r_enc       <= w_next;
      r_tail      <= r_tail + TW'(1);
      r_sym_last  <= w_tail_end;
      if (w_tail_end) begin
        r_fsm <= ST_RUN;
      end
    end else if (i_sym_ready) begin
      r_sym_valid <= 1'b0;
      r_sym_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Directed bench for conv_encoder_stream: K=3 07/05
// scenarios plus a K=7 171/133 random-bit run.
module tb_conv_encoder_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_bit, in_last, sym_ready;
  logic       in_ready, sym_valid, sym_last, busy;
  logic [1:0] sym;

  logic       in7_valid, in7_bit, in7_last;
  logic       in7_ready, sym7_valid, sym7_last, busy7;
  logic [1:0] sym7;

  int cmps = 0;
  int errs = 0;
  bit rnd_ready = 1'b0;

  logic [1:0] q_sym[$];
  logic       q_last[$];
  logic [1:0] q7_sym[$];
  logic       q7_last[$];

  int         stall_viol = 0;
  int         stall_seen = 0;
  logic       pv_stall = 1'b0;
  logic [1:0] pv_sym;
  logic       pv_last;

  always #5 clk = ~clk;

  conv_encoder_stream u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_bit   (in_bit),
    .i_in_last  (in_last),
    .o_sym_valid(sym_valid),
    .i_sym_ready(sym_ready),
    .o_sym      (sym),
    .o_sym_last (sym_last),
    .o_busy     (busy)
  );

  conv_encoder_stream #(
    .K     (7),
    .G0_OCT(8'o171),
    .G1_OCT(8'o133)
  ) u_dut7 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in7_valid),
    .o_in_ready (in7_ready),
    .i_in_bit   (in7_bit),
    .i_in_last  (in7_last),
    .o_sym_valid(sym7_valid),
    .i_sym_ready(1'b1),
    .o_sym      (sym7),
    .o_sym_last (sym7_last),
    .o_busy     (busy7)
  );

  // Downstream ready: steady or random, changed just after each edge
  initial begin
    sym_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sym_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Collect handshaken symbols and watch for changes while stalled
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (pv_stall && (sym_valid !== 1'b1 || sym !== pv_sym ||
                       sym_last !== pv_last))
        stall_viol++;
      if (sym_valid && !sym_ready) stall_seen++;
      pv_stall = sym_valid && !sym_ready;
      pv_sym   = sym;
      pv_last  = sym_last;
      if (sym_valid && sym_ready) begin
        q_sym.push_back(sym);
        q_last.push_back(sym_last);
      end
      if (sym7_valid) begin
        q7_sym.push_back(sym7);
        q7_last.push_back(sym7_last);
      end
    end else begin
      pv_stall = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
    in7_valid = 1'b0;
    in7_bit   = 1'b0;
    in7_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_sym.delete();
    q_last.delete();
  endtask

  task automatic send_bit(input logic b, input logic l, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    while (!acc && waits <= 200) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) waits++;
    end
    @(posedge clk);
    #1;
    if (!acc) begin
      cmps++;
      errs++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic wait_syms(input int n);
    int c;
    c = 0;
    while (q_sym.size() < n && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    cmps++;
    if (q_sym.size() !== n) begin
      errs++;
      $display("FAIL sym_count: got %0d, required %0d", q_sym.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cmps += 5;
    if (sym_valid !== 1'b0) begin
      errs++; $display("FAIL rst_sym_valid: got %b, required 0", sym_valid);
    end
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL rst_in_ready: got %b, required 1", in_ready);
    end
    if (busy !== 1'b0) begin
      errs++; $display("FAIL rst_busy: got %b, required 0", busy);
    end
    if (sym !== 2'b00) begin
      errs++; $display("FAIL rst_sym: got %b, required 00", sym);
    end
    if (sym_last !== 1'b0) begin
      errs++; $display("FAIL rst_sym_last: got %b, required 0", sym_last);
    end
  endtask

  task automatic run_frame1(input string tag, input bit chk_waits);
    logic       bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_s [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic       exp_l [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int w;
    int wsum;
    wsum = 0;
    q_sym.delete();
    q_last.delete();
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[i], (i == 3), w);
      wsum += w;
    end
    in_valid = 1'b0;
    wait_syms(6);
    if (chk_waits) begin
      cmps++;
      if (wsum !== 0) begin
        errs++;
        $display("FAIL %s_in_ready_drop: waits %0d, required 0", tag, wsum);
      end
    end
    for (int i = 0; i < 6 && i < q_sym.size(); i++) begin
      cmps += 2;
      if (q_sym[i] !== exp_s[i]) begin
        errs++;
        $display("FAIL %s_sym%0d: got %b, required %b", tag, i, q_sym[i], exp_s[i]);
      end
      if (q_last[i] !== exp_l[i]) begin
        errs++;
        $display("FAIL %s_last%0d: got %b, required %b", tag, i, q_last[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_frame();
    rnd_ready = 1'b0;
    run_frame1("frame", 1'b1);
  endtask

  task automatic test_backpressure();
    stall_viol = 0;
    stall_seen = 0;
    rnd_ready  = 1'b1;
    run_frame1("bp", 1'b0);
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    cmps++;
    if (stall_viol !== 0) begin
      errs++;
      $display("FAIL bp_stall_hold: %0d changes, required 0", stall_viol);
    end
  endtask

  task automatic test_back_to_back();
    logic       bits [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_s [9] = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b10,
                              2'b11, 2'b11, 2'b10, 2'b11};
    logic       exp_l [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b1};
    int w;
    int w1;
    rnd_ready = 1'b0;
    q_sym.delete();
    q_last.delete();
    w1 = 0;
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[i], (i == 3), w);
      w1 += w;
    end
    send_bit(bits[4], 1'b1, w);
    in_valid = 1'b0;
    cmps += 2;
    if (w1 !== 0) begin
      errs++; $display("FAIL b2b_data_waits: got %0d, required 0", w1);
    end
    if (w !== 2) begin
      errs++; $display("FAIL b2b_tail_waits: got %0d, required 2", w);
    end
    wait_syms(9);
    for (int i = 0; i < 9 && i < q_sym.size(); i++) begin
      cmps += 2;
      if (q_sym[i] !== exp_s[i]) begin
        errs++;
        $display("FAIL b2b_sym%0d: got %b, required %b", i, q_sym[i], exp_s[i]);
      end
      if (q_last[i] !== exp_l[i]) begin
        errs++;
        $display("FAIL b2b_last%0d: got %b, required %b", i, q_last[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_in_tail();
    logic       bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_s [3] = '{2'b11, 2'b10, 2'b11};
    logic       exp_l [3] = '{1'b0, 1'b0, 1'b1};
    int w;
    rnd_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(bits[i], (i == 3), w);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    cmps += 2;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL rt_busy_tail: got %b, required 1", busy);
    end
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL rt_ready_tail: got %b, required 0", in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmps += 3;
    if (sym_valid !== 1'b0) begin
      errs++; $display("FAIL rt_sym_valid: got %b, required 0", sym_valid);
    end
    if (busy !== 1'b0) begin
      errs++; $display("FAIL rt_busy: got %b, required 0", busy);
    end
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL rt_in_ready: got %b, required 1", in_ready);
    end
    q_sym.delete();
    q_last.delete();
    send_bit(1'b1, 1'b1, w);
    in_valid = 1'b0;
    wait_syms(3);
    for (int i = 0; i < 3 && i < q_sym.size(); i++) begin
      cmps += 2;
      if (q_sym[i] !== exp_s[i]) begin
        errs++;
        $display("FAIL rt_sym%0d: got %b, required %b", i, q_sym[i], exp_s[i]);
      end
      if (q_last[i] !== exp_l[i]) begin
        errs++;
        $display("FAIL rt_last%0d: got %b, required %b", i, q_last[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_k7();
    logic [6:0] h;
    logic [1:0] exp_s [70];
    logic       exp_l [70];
    logic       b;
    logic       acc;
    int         c;
    q7_sym.delete();
    q7_last.delete();
    h = '0;
    for (int i = 0; i < 70; i++) begin
      b = (i == 0) ? 1'b1 : ((i < 64) ? 1'($urandom_range(0, 1)) : 1'b0);
      h = {h[5:0], b};
      exp_s[i] = {^(h & 7'o171), ^(h & 7'o133)};
      exp_l[i] = (i == 69);
      if (i < 64) begin
        in7_valid = 1'b1;
        in7_bit   = b;
        in7_last  = (i == 63);
        acc = 1'b0;
        c   = 0;
        while (!acc && c < 50) begin
          @(negedge clk);
          acc = in7_ready;
          c++;
        end
        @(posedge clk);
        #1;
        if (!acc) begin
          cmps++; errs++;
          $display("FAIL k7_timeout: in_ready 0 at bit %0d, required 1", i);
        end
      end
    end
    in7_valid = 1'b0;
    in7_last  = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    cmps += 2;
    if (q7_sym.size() !== 70) begin
      errs++; $display("FAIL k7_count: got %0d, required 70", q7_sym.size());
    end
    if (q7_sym.size() > 0 && q7_sym[0] !== 2'b11) begin
      errs++; $display("FAIL k7_first: got %b, required 11", q7_sym[0]);
    end
    for (int i = 0; i < 70 && i < q7_sym.size(); i++) begin
      cmps += 2;
      if (q7_sym[i] !== exp_s[i]) begin
        errs++;
        $display("FAIL k7_sym%0d: got %b, required %b", i, q7_sym[i], exp_s[i]);
      end
      if (q7_last[i] !== exp_l[i]) begin
        errs++;
        $display("FAIL k7_last%0d: got %b, required %b", i, q7_last[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_in_tail();
    test_k7();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
